// File: rtl/csa_iter_multiplier.sv
// rtl/csa_iter_multiplier.sv - iterative carry-save multiplier, ROWS partial-product rows per cycle
// Signed mode uses Baugh-Wooley: inverted sign-cross bits plus a constant folded into the first carry input.
module csa_iter_multiplier #(
  parameter int WIDTH = 32,
  parameter int ROWS  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - ROWS);
  localparam logic [CW-1:0] CNT_STEP = CW'(ROWS);
  // 2^WIDTH + 2^(2*WIDTH-1): the Baugh-Wooley correction, modulo 2^(2*WIDTH)
  localparam logic [PW-1:0] BW_CORR = {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             signed_q;
  logic [PW-1:0]    sum_q;
  logic [PW-1:0]    carry_q;
  logic [PW-1:0]    product_q;
  logic [CW-1:0]    cnt_q;
  logic             ready_q;
  logic             done_q;

  logic [PW-1:0]    sum_d;
  logic [PW-1:0]    carry_d;
  logic [ROWS-1:0]  b_bits;
  logic [WIDTH-1:0] row;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    s_acc;
  logic [PW-1:0]    c_acc;
  logic [PW-1:0]    s_next;

  always_comb begin
    b_bits = ROWS'(b_q >> cnt_q);
    row    = '0;
    pp     = '0;
    s_next = '0;
    s_acc  = sum_q;
    // carry is cleared on acceptance, so the first cycle can carry the correction instead
    c_acc  = (cnt_q == '0) ? (signed_q ? BW_CORR : '0) : carry_q;
    for (int r = 0; r < ROWS; r++) begin
      row = a_q & {WIDTH{b_bits[r]}};
      if (signed_q) begin
        if (int'(cnt_q) + r == WIDTH - 1) begin
          row[WIDTH-2:0] = ~row[WIDTH-2:0];
        end else begin
          row[WIDTH-1] = ~row[WIDTH-1];
        end
      end
      pp     = {{WIDTH{1'b0}}, row} << (int'(cnt_q) + r);
      s_next = s_acc ^ c_acc ^ pp;
      c_acc  = ((s_acc & c_acc) | (s_acc & pp) | (c_acc & pp)) << 1;
      s_acc  = s_next;
    end
    sum_d   = s_acc;
    carry_d = c_acc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            signed_q <= signed_mode;
            sum_q    <= '0;
            carry_q  <= '0;
            cnt_q    <= '0;
            state_q  <= ACCUM;
            ready_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end
        end
        ACCUM: begin
          sum_q   <= sum_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CNT_STEP;
          if (cnt_q == LAST_CNT) begin
            state_q <= RESOLVE;
          end
        end
        RESOLVE: begin
          product_q <= sum_q + carry_q;
          state_q   <= DONE;
          ready_q   <= 1'b1;
          done_q    <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready   = ready_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
